// File: rtl/vx_reg_scoreboard.sv
// Per-warp register scoreboard: holds back issue of instructions with RAW/WAW hazards
// and registers accepted instructions for operand collection. Optional macro: SCOREBOARD_PERF_EN.
module vx_reg_scoreboard #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 64,
  parameter int DATAW     = 128,
  localparam int WIS_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NR_BITS  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ibuf_valid,
  output logic                 o_ibuf_ready,
  input  logic [WIS_W-1:0]     i_ibuf_wis,
  input  logic                 i_ibuf_wb,
  input  logic [NR_BITS-1:0]   i_ibuf_rd,
  input  logic [NR_BITS-1:0]   i_ibuf_rs1,
  input  logic [NR_BITS-1:0]   i_ibuf_rs2,
  input  logic [NR_BITS-1:0]   i_ibuf_rs3,
  input  logic [DATAW-1:0]     i_ibuf_payload,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [WIS_W-1:0]     o_out_wis,
  output logic                 o_out_wb,
  output logic [NR_BITS-1:0]   o_out_rd,
  output logic [NR_BITS-1:0]   o_out_rs1,
  output logic [NR_BITS-1:0]   o_out_rs2,
  output logic [NR_BITS-1:0]   o_out_rs3,
  output logic [DATAW-1:0]     o_out_payload,
  input  logic                 i_wb_valid,
  input  logic [WIS_W-1:0]     i_wb_wis,
  input  logic [NR_BITS-1:0]   i_wb_rd,
  input  logic                 i_wb_eop,
  output logic [NUM_WARPS-1:0] o_pending_any,
  output logic [31:0]          o_perf_stalls
);

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] r_pending;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] w_set_mask;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0]                w_row;
  logic                               w_hazard;
  logic                               w_fire;
  logic                               w_release;
  logic                               r_out_valid;

  // Hazard looks only at registered state; a writeback this cycle frees the slot next cycle.
  assign w_row    = r_pending[i_ibuf_wis];
  assign w_hazard = i_ibuf_valid && (
                      ((i_ibuf_rs1 != '0) && w_row[i_ibuf_rs1]) ||
                      ((i_ibuf_rs2 != '0) && w_row[i_ibuf_rs2]) ||
                      ((i_ibuf_rs3 != '0) && w_row[i_ibuf_rs3]) ||
                      (i_ibuf_wb && (i_ibuf_rd != '0) && w_row[i_ibuf_rd]));

  assign o_ibuf_ready = !w_hazard && (!r_out_valid || i_out_ready);
  assign w_fire       = i_ibuf_valid && o_ibuf_ready;
  assign w_release    = i_wb_valid && i_wb_eop;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      for (gj = 0; gj < NUM_REGS; gj++) begin : g_reg
        // Register 0 is hardwired: never marked, never tracked.
        assign w_set_mask[gi][gj] = (gj != 0) && w_fire && i_ibuf_wb &&
                                    (i_ibuf_wis == WIS_W'(gi)) && (i_ibuf_rd == NR_BITS'(gj));
        assign w_clr_mask[gi][gj] = w_release &&
                                    (i_wb_wis == WIS_W'(gi)) && (i_wb_rd == NR_BITS'(gj));
      end
      assign o_pending_any[gi] = |r_pending[gi];
    end
  endgenerate

  // Clear wins over set on the same bit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending | w_set_mask) & ~w_clr_mask;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;

  // Data fields need no reset; they only matter while out_valid is high.
  always_ff @(posedge i_clk) begin
    if (w_fire) begin
      o_out_wis     <= i_ibuf_wis;
      o_out_wb      <= i_ibuf_wb;
      o_out_rd      <= i_ibuf_rd;
      o_out_rs1     <= i_ibuf_rs1;
      o_out_rs2     <= i_ibuf_rs2;
      o_out_rs3     <= i_ibuf_rs3;
      o_out_payload <= i_ibuf_payload;
    end
  end

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] r_perf_stalls;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_perf_stalls <= '0;
    end else if (w_hazard) begin
      r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign o_perf_stalls = r_perf_stalls;
`else
  assign o_perf_stalls = '0;
`endif

  // A release must target a register that is actually outstanding.
  a_release_pending : assert property (@(posedge i_clk) disable iff (i_reset)
    w_release |-> r_pending[i_wb_wis][i_wb_rd]);

endmodule

// File: tb/tb_vx_reg_scoreboard.sv
// Directed-vector bench for vx_reg_scoreboard with hand-computed expectations.
module tb_vx_reg_scoreboard;

  logic         clk = 1'b0;
  logic         reset;
  logic         ibuf_valid;
  logic         ibuf_ready;
  logic [1:0]   ibuf_wis;
  logic         ibuf_wb;
  logic [5:0]   ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
  logic [127:0] ibuf_payload;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_wis;
  logic         out_wb;
  logic [5:0]   out_rd, out_rs1, out_rs2, out_rs3;
  logic [127:0] out_payload;
  logic         wb_valid;
  logic [1:0]   wb_wis;
  logic [5:0]   wb_rd;
  logic         wb_eop;
  logic [3:0]   pending_any;
  logic [31:0]  perf_stalls;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vx_reg_scoreboard dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_ibuf_valid   (ibuf_valid),
    .o_ibuf_ready   (ibuf_ready),
    .i_ibuf_wis     (ibuf_wis),
    .i_ibuf_wb      (ibuf_wb),
    .i_ibuf_rd      (ibuf_rd),
    .i_ibuf_rs1     (ibuf_rs1),
    .i_ibuf_rs2     (ibuf_rs2),
    .i_ibuf_rs3     (ibuf_rs3),
    .i_ibuf_payload (ibuf_payload),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_wis      (out_wis),
    .o_out_wb       (out_wb),
    .o_out_rd       (out_rd),
    .o_out_rs1      (out_rs1),
    .o_out_rs2      (out_rs2),
    .o_out_rs3      (out_rs3),
    .o_out_payload  (out_payload),
    .i_wb_valid     (wb_valid),
    .i_wb_wis       (wb_wis),
    .i_wb_rd        (wb_rd),
    .i_wb_eop       (wb_eop),
    .o_pending_any  (pending_any),
    .o_perf_stalls  (perf_stalls)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ib(input logic v, input logic [1:0] wis, input logic wb, input logic [5:0] rd,
                        input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rs3,
                        input logic [127:0] pl);
    ibuf_valid   = v;
    ibuf_wis     = wis;
    ibuf_wb      = wb;
    ibuf_rd      = rd;
    ibuf_rs1     = rs1;
    ibuf_rs2     = rs2;
    ibuf_rs3     = rs3;
    ibuf_payload = pl;
  endtask

  task automatic set_wb(input logic v, input logic [1:0] wis, input logic [5:0] rd, input logic eop);
    wb_valid = v;
    wb_wis   = wis;
    wb_rd    = rd;
    wb_eop   = eop;
  endtask

  initial begin
    logic [31:0] exp_perf;
`ifdef SCOREBOARD_PERF_EN
    exp_perf = 32'd7;
`else
    exp_perf = 32'd0;
`endif
    reset     = 1'b1;
    out_ready = 1'b1;
    set_ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 128'h0);
    set_wb(1'b0, 2'd0, 6'd0, 1'b0);
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_pending_any", pending_any, 4'b0000);
    check("rst_ibuf_ready", ibuf_ready, 1'b1);
    check("rst_perf", perf_stalls, 32'd0);
    step();
    reset = 1'b0;
    step();

    // First issue: warp 0 writes r5
    set_ib(1'b1, 2'd0, 1'b1, 6'd5, 6'd1, 6'd2, 6'd3, 128'hA1);
    #1 check("issue1_ready", ibuf_ready, 1'b1);
    step();
    check("issue1_out_valid", out_valid, 1'b1);
    check("issue1_out_rd", out_rd, 6'd5);
    check("issue1_payload", out_payload, 128'hA1);
    check("issue1_pending_any", pending_any, 4'b0001);

    // RAW on r5, release at T
    set_ib(1'b1, 2'd0, 1'b1, 6'd6, 6'd5, 6'd0, 6'd0, 128'hA2);
    set_wb(1'b1, 2'd0, 6'd5, 1'b1);
    #1 check("raw_stall_ready", ibuf_ready, 1'b0);
    step();
    set_wb(1'b0, 2'd0, 6'd0, 1'b0);
    #1 check("raw_T1_ready", ibuf_ready, 1'b1);
    check("raw_T1_out_valid", out_valid, 1'b0);
    step();
    check("raw_T2_out_valid", out_valid, 1'b1);
    check("raw_T2_payload", out_payload, 128'hA2);
    check("raw_T2_rs1", out_rs1, 6'd5);
    check("raw_T2_pending_any", pending_any, 4'b0001);

    // Other warp reading the same register number is independent
    set_ib(1'b1, 2'd1, 1'b1, 6'd7, 6'd6, 6'd0, 6'd0, 128'hA3);
    #1 check("warp1_ready", ibuf_ready, 1'b1);
    step();
    check("warp1_out_wis", out_wis, 2'd1);
    check("warp1_payload", out_payload, 128'hA3);
    check("warp1_pending_any", pending_any, 4'b0011);

    // Backpressure for 3 cycles
    out_ready = 1'b0;
    set_ib(1'b1, 2'd2, 1'b1, 6'd9, 6'd0, 6'd0, 6'd0, 128'hA4);
    #1 check("bp_ready", ibuf_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp%0d_out_valid", i), out_valid, 1'b1);
      check($sformatf("bp%0d_payload", i), out_payload, 128'hA3);
      check($sformatf("bp%0d_ready", i), ibuf_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", ibuf_ready, 1'b1);
    step();
    check("bp_next_payload", out_payload, 128'hA4);
    check("bp_next_wb", out_wb, 1'b1);
    check("bp_pending_any", pending_any, 4'b0111);

    // rs3 and WAW hazards, and wb=0 ignoring rd
    set_ib(1'b1, 2'd2, 1'b0, 6'd0, 6'd0, 6'd0, 6'd9, 128'hA5);
    #1 check("rs3_hazard_ready", ibuf_ready, 1'b0);
    set_ib(1'b1, 2'd0, 1'b1, 6'd6, 6'd0, 6'd0, 6'd0, 128'hA5);
    #1 check("waw_hazard_ready", ibuf_ready, 1'b0);
    set_ib(1'b1, 2'd0, 1'b0, 6'd6, 6'd0, 6'd0, 6'd0, 128'hA5);
    #1 check("nowb_rd_ready", ibuf_ready, 1'b1);

    // rd=0 with wb never marks pending
    set_ib(1'b1, 2'd3, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0, 128'hA6);
    #1 check("rd0_ready", ibuf_ready, 1'b1);
    step();
    check("rd0_payload", out_payload, 128'hA6);
    check("rd0_out_rd", out_rd, 6'd0);
    check("rd0_pending_any", pending_any, 4'b0111);

    // Non-eop writeback beat changes nothing; eop beat releases
    set_ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 128'h0);
    set_wb(1'b1, 2'd0, 6'd6, 1'b0);
    step();
    check("noneop_pending_any", pending_any, 4'b0111);
    check("drain_out_valid", out_valid, 1'b0);
    set_wb(1'b1, 2'd0, 6'd6, 1'b1);
    step();
    set_wb(1'b0, 2'd0, 6'd0, 1'b0);
    check("eop_pending_any", pending_any, 4'b0110);

    // Set warp0 r10 and clear warp1 r7 in the same cycle
    set_ib(1'b1, 2'd0, 1'b1, 6'd10, 6'd0, 6'd0, 6'd0, 128'hA7);
    set_wb(1'b1, 2'd1, 6'd7, 1'b1);
    #1 check("setclr_ready", ibuf_ready, 1'b1);
    step();
    set_ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 128'h0);
    set_wb(1'b0, 2'd0, 6'd0, 1'b0);
    check("setclr_pending_any", pending_any, 4'b0101);
    check("setclr_payload", out_payload, 128'hA7);

    // Reset discards everything
    reset = 1'b1;
    #1 check("rst2_pending_any", pending_any, 4'b0000);
    check("rst2_out_valid", out_valid, 1'b0);
    check("rst2_ready", ibuf_ready, 1'b1);
    step();
    reset = 1'b0;
    step();

    // Stall counter: hazard held for 7 cycles, then reset mid-stall
    set_ib(1'b1, 2'd0, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0, 128'hB1);
    step();
    check("perf_pending_any", pending_any, 4'b0001);
    set_ib(1'b1, 2'd0, 1'b1, 6'd8, 6'd5, 6'd0, 6'd0, 128'hB2);
    #1 check("perf_stall_ready", ibuf_ready, 1'b0);
    repeat (7) step();
    check("perf_stalls_7", perf_stalls, exp_perf);
    #2 reset = 1'b1;
    #1 check("perf_rst_stalls", perf_stalls, 32'd0);
    check("perf_rst_pending_any", pending_any, 4'b0000);
    check("perf_rst_out_valid", out_valid, 1'b0);
    set_ib(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 128'h0);
    step();
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_reg_scoreboard.md
VX_REG_SCOREBOARD -- requirements
Module: VX_reg_scoreboard

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, warps sharing this issue slot (ISSUE_RATIO).
REQ-002 SHALL have parameter NUM_REGS, default 64, architectural registers per warp, int+fp.
REQ-003 SHALL have parameter DATAW, default 128, opaque pass-through payload width (uuid, tmask, PC, op fields, imm).
REQ-004 SHALL derive localparams WIS_W = LOG2UP(NUM_WARPS) and NR_BITS = LOG2UP(NUM_REGS).
REQ-005 clk  input  1  clock; one clock domain.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ibuf_valid / ibuf_ready  input / output  1 / 1  instruction-buffer handshake.
REQ-008 ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3  input  WIS_W, 1, NR_BITS x4  warp slot, writes-back flag, dest and source registers.
REQ-009 ibuf_payload  input  DATAW  pass-through payload.
REQ-010 out_valid / out_ready  output / input  1 / 1  handshake to operand-collection stage.
REQ-011 out_wis, out_wb, out_rd, out_rs1, out_rs2, out_rs3, out_payload  output  same widths as inputs  registered copy of accepted instruction.
REQ-012 wb_valid, wb_wis, wb_rd, wb_eop  input  1, WIS_W, NR_BITS, 1  writeback release; release occurs only on eop beat.
REQ-013 pending_any  output  NUM_WARPS  bit w = warp w has any outstanding register write.
REQ-014 perf_stalls  output  32  hazard-stall cycle count.

Function
REQ-015 SHALL keep pending bitmap pending[NUM_WARPS][NUM_REGS], registered.
REQ-016 hazard = ibuf_valid AND (pending[wis][rs1] OR pending[wis][rs2] OR pending[wis][rs3] OR (ibuf_wb AND pending[wis][rd])), using registered state only; no same-cycle writeback bypass.
REQ-017 Register 0 SHALL never be pending; rs==0 or rd==0 SHALL never cause hazard.
REQ-018 ibuf_ready = ~hazard AND (~out_valid OR out_ready); fire = ibuf_valid AND ibuf_ready.
REQ-019 On fire, output register SHALL load all ibuf fields and set out_valid=1 next cycle; latency exactly 1 cycle.
REQ-020 On out_valid AND out_ready without fire, out_valid SHALL clear next cycle; fire with out_ready SHALL give back-to-back issue at 1 instr/cycle.
REQ-021 Output fields SHALL hold stable while out_valid AND ~out_ready.
REQ-022 On fire with ibuf_wb=1 and ibuf_rd!=0, pending[wis][rd] SHALL set next cycle.
REQ-023 On wb_valid AND wb_eop, pending[wb_wis][wb_rd] SHALL clear next cycle; non-eop beats SHALL not change state.
REQ-024 Set and clear on same bit same cycle cannot be legal (set requires bit clear); clear SHALL win, and simulation assertion SHALL flag release of a non-pending bit.
REQ-025 Set and clear on different bits same cycle SHALL both take effect.
REQ-026 pending_any[w] SHALL be OR-reduction of registered pending[w].
REQ-027 No ibuf_* input other than handshake SHALL be sampled when ibuf_valid=0.

Reset
REQ-028 reset SHALL asynchronously clear pending, out_valid, perf_stalls; pending_any=0, ibuf_ready reflects empty output register.
REQ-029 out_* data fields need no reset; reset mid-operation SHALL discard the held instruction and all pending marks.

Configuration
REQ-030 Macro SCOREBOARD_PERF_EN: defined -> perf_stalls increments by 1 each cycle ibuf_valid AND hazard, wraps at 2^32; undefined -> perf_stalls tied to 0, no counter logic.

Verification
REQ-031 Reset, ibuf_valid=1 wis=0 rd=5 wb=1 rs=1,2,3, out_ready=1 -> out_valid next cycle, pending[0][5]=1, pending_any=4'b0001.
REQ-032 Then wis=0 rs1=5 -> ibuf_ready=0; wb_valid wis=0 rd=5 eop=1 at cycle T -> ibuf_ready=1 at T+1, out_valid at T+2.
REQ-033 Warp 1 rs1=5 while pending[0][5]=1 -> no stall, issues in 1 cycle.
REQ-034 out_ready=0 for 3 cycles with out_valid=1 -> ibuf_ready=0, out_payload constant; out_ready=1 -> next instruction accepted same cycle.
REQ-035 rd=0 wb=1 issued -> pending unchanged; wb_valid eop=0 rd=5 -> pending[0][5] unchanged.
REQ-036 SCOREBOARD_PERF_EN defined, hazard held 7 cycles -> perf_stalls=7; assert reset mid-stall -> perf_stalls=0, pending_any=0 immediately.
